int_issue_queue: RTL and testbench
==================================

INT_ISSUE_QUEUE -- requirements
Module: int_issue_queue

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, operand/immediate width.
REQ-002 The block SHALL have parameter TAG_WIDTH, default 6, rename tag width.
REQ-003 The block SHALL have parameter DEPTH, default 4, number of queue entries (power of two, >=2).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port dispatch_en_integer, input, 1 bit: dispatch write strobe.
REQ-007 The block SHALL have port dispatch_opcode, input, 5 bits: ALU operation code.
REQ-008 The block SHALL have ports dispatch_rd_tag, dispatch_rs1_tag and dispatch_rs2_tag, all inputs of TAG_WIDTH bits.
REQ-009 The block SHALL have ports dispatch_rs1_data, dispatch_rs2_data and dispatch_imm, all inputs of DATA_WIDTH bits.
REQ-010 The block SHALL have ports dispatch_rs1_valid and dispatch_rs2_valid, inputs, 1 bit each: 1 = operand pending on its tag, 0 = data field holds the operand.
REQ-011 The block SHALL have ports CDB_valid (input, 1), CDB_tag (input, TAG_WIDTH) and CDB_data (input, DATA_WIDTH): the result broadcast.
REQ-012 The block SHALL have port issueque_full_integer, output, 1 bit: queue holds DEPTH entries.
REQ-013 The block SHALL have ports issue_valid (output, 1) and issue_ready (input, 1): the handshake to the integer execution unit.
REQ-014 The block SHALL have outputs issue_opcode (5), issue_rd_tag (TAG_WIDTH), issue_rs1_data, issue_rs2_data and issue_imm (DATA_WIDTH each).

Function
REQ-015 Each entry SHALL hold: busy, opcode, rd_tag, imm, and per operand a pending bit, a tag and data.
REQ-016 Entries SHALL be age-ordered, with index 0 the oldest; on removal, younger entries SHALL shift down one slot in the same edge (collapsing queue).
REQ-017 A dispatch with dispatch_en_integer=1 and issueque_full_integer=0 SHALL write the lowest free slot at the next edge; with issueque_full_integer=1 the dispatch SHALL be ignored.
REQ-018 issueque_full_integer SHALL equal (count==DEPTH), driven from registered count, with no combinational path from issue_ready.
REQ-019 With CDB_valid=1, every busy pending operand whose tag equals CDB_tag SHALL capture CDB_data and clear its pending bit; both operands of one entry SHALL update if both match.
REQ-020 A dispatched operand with valid=1 whose tag equals CDB_tag while CDB_valid=1 in the same cycle SHALL be written as ready with CDB_data.
REQ-021 An entry SHALL be ready when busy and both pending bits are 0.
REQ-022 issue_valid SHALL be 1 iff any entry is ready; the issue_* fields SHALL come from the oldest ready entry.
REQ-023 issue_valid & issue_ready SHALL remove the selected entry at the edge; issue_* SHALL stay stable while issue_valid=1 and issue_ready=0, unless an older entry becomes ready.
REQ-024 Dispatch and issue in the same cycle SHALL both take effect: count is unchanged and the new entry lands after compaction.
REQ-025 A fully-ready dispatch SHALL become issuable no earlier than the cycle after it is written (minimum latency of 1 cycle).
REQ-026 The imm field SHALL pass through unmodified.

Reset
REQ-027 While reset=0, all busy and pending bits and count SHALL be 0, and issue_valid=0 and issueque_full_integer=0 asynchronously; data fields are don't-care.
REQ-028 Assertion of reset mid-operation SHALL discard all entries; the first dispatch after deassertion SHALL be accepted in the first clock.

Configuration
REQ-029 Macro IQ_CDB_BYPASS_EN, when defined, SHALL make an entry whose last pending operand matches the CDB this cycle eligible for issue in that same cycle, with CDB_data muxed onto the issue operand.
REQ-030 Without IQ_CDB_BYPASS_EN, such an entry SHALL become eligible in the cycle after capture, and there SHALL be no combinational path from the CDB inputs to the issue_* outputs.

Verification
REQ-031 The bench SHALL cover: reset, dispatch opcode=3, rs1=5, rs2=7, both valid=0, issue_ready=1 -> issue_valid=1 next cycle with rs1_data=5, rs2_data=7; queue empty after.
REQ-032 The bench SHALL cover: issue_ready=0, 4 ready dispatches -> issueque_full_integer=1 after the 4th; a 5th dispatch is dropped; one issue -> full=0 and count=3.
REQ-033 The bench SHALL cover: entry A waiting on tag 9 followed by ready entry B -> B issues first; CDB_valid=1, tag=9, data=0xABCD -> A issues with rs1_data=0xABCD (same cycle with the macro, next cycle without).
REQ-034 The bench SHALL cover: a dispatch with rs2_valid=1, tag=12 coinciding with CDB tag=12, data=0x55 -> entry written ready and issues with rs2_data=0x55.
REQ-035 The bench SHALL cover: queue full while simultaneously issuing and asserting dispatch -> dispatch dropped and count=3; at count=3, issue plus dispatch -> count stays 3 with order preserved.
REQ-036 The bench SHALL cover: reset driven low while 3 entries are busy -> issue_valid=0 immediately; after release, an accepted dispatch issues normally.

Source files
------------

// File: rtl/int_issue_queue.sv
// int_issue_queue: collapsing, age-ordered integer issue queue with CDB operand wakeup.
// Optional feature macro: IQ_CDB_BYPASS_EN (an entry woken by the CDB may issue in that same cycle).
// Ports:
//   clk, reset            : clock and asynchronous active-low reset
//   dispatch_*            : write strobe, opcode, rd/rs tags, operand data, pending flags, immediate
//   CDB_valid/tag/data    : result broadcast that wakes pending operands
//   issueque_full_integer : queue holds DEPTH entries (from registered count only)
//   issue_valid/ready     : handshake to the integer execution unit
//   issue_*               : fields of the oldest ready entry
module int_issue_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 6,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  dispatch_en_integer,
    input  logic [4:0]            dispatch_opcode,
    input  logic [TAG_WIDTH-1:0]  dispatch_rd_tag,
    input  logic [TAG_WIDTH-1:0]  dispatch_rs1_tag,
    input  logic [TAG_WIDTH-1:0]  dispatch_rs2_tag,
    input  logic [DATA_WIDTH-1:0] dispatch_rs1_data,
    input  logic [DATA_WIDTH-1:0] dispatch_rs2_data,
    input  logic [DATA_WIDTH-1:0] dispatch_imm,
    input  logic                  dispatch_rs1_valid,
    input  logic                  dispatch_rs2_valid,
    input  logic                  CDB_valid,
    input  logic [TAG_WIDTH-1:0]  CDB_tag,
    input  logic [DATA_WIDTH-1:0] CDB_data,
    output logic                  issueque_full_integer,
    output logic                  issue_valid,
    input  logic                  issue_ready,
    output logic [4:0]            issue_opcode,
    output logic [TAG_WIDTH-1:0]  issue_rd_tag,
    output logic [DATA_WIDTH-1:0] issue_rs1_data,
    output logic [DATA_WIDTH-1:0] issue_rs2_data,
    output logic [DATA_WIDTH-1:0] issue_imm
);
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic                  busy;
        logic [4:0]            op;
        logic [TAG_WIDTH-1:0]  rd;
        logic [DATA_WIDTH-1:0] imm;
        logic                  p1;
        logic [TAG_WIDTH-1:0]  t1;
        logic [DATA_WIDTH-1:0] d1;
        logic                  p2;
        logic [TAG_WIDTH-1:0]  t2;
        logic [DATA_WIDTH-1:0] d2;
    } entry_t;

    entry_t          r_q   [DEPTH];
    entry_t          w_cur [DEPTH];
    entry_t          w_nxt [DEPTH];
    entry_t          w_raw;
    entry_t          w_new;
    logic [IW:0]     r_count;
    logic [IW:0]     w_after;
    logic [IW-1:0]   w_sel;
    logic [DEPTH-1:0] w_rdy;
    logic            w_acc;
    logic            w_fire;

    // Apply a CDB broadcast to an entry: matching pending operands capture the data.
    function automatic entry_t wake(entry_t e, logic v, logic [TAG_WIDTH-1:0] t, logic [DATA_WIDTH-1:0] d);
        wake = e;
        if (v && e.busy && e.p1 && e.t1 == t) begin
            wake.p1 = 1'b0;
            wake.d1 = d;
        end
        if (v && e.busy && e.p2 && e.t2 == t) begin
            wake.p2 = 1'b0;
            wake.d2 = d;
        end
    endfunction

    assign issueque_full_integer = r_count == (IW+1)'(DEPTH);
    assign w_acc   = dispatch_en_integer & ~issueque_full_integer;
    assign w_fire  = issue_valid & issue_ready;
    assign w_after = r_count - (IW+1)'(w_fire);

    assign w_raw = '{busy: 1'b1, op: dispatch_opcode, rd: dispatch_rd_tag, imm: dispatch_imm,
                     p1: dispatch_rs1_valid, t1: dispatch_rs1_tag, d1: dispatch_rs1_data,
                     p2: dispatch_rs2_valid, t2: dispatch_rs2_tag, d2: dispatch_rs2_data};
    // A dispatch coinciding with its producer's broadcast is written already captured.
    assign w_new = wake(w_raw, CDB_valid, CDB_tag, CDB_data);

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        assign w_cur[i] = wake(r_q[i], CDB_valid, CDB_tag, CDB_data);
`ifdef IQ_CDB_BYPASS_EN
        assign w_rdy[i] = w_cur[i].busy & ~w_cur[i].p1 & ~w_cur[i].p2;
`else
        assign w_rdy[i] = r_q[i].busy & ~r_q[i].p1 & ~r_q[i].p2;
`endif
        // Slots at or above the issued one take their upper neighbour; the new entry
        // lands at the first free slot after that compaction.
        if (i == DEPTH - 1) begin : g_top
            assign w_nxt[i] = (w_acc && w_after == (IW+1)'(i)) ? w_new :
                              w_fire ? '0 : w_cur[i];
        end else begin : g_mid
            assign w_nxt[i] = (w_acc && w_after == (IW+1)'(i)) ? w_new :
                              (w_fire && w_sel <= IW'(i)) ? w_cur[i+1] : w_cur[i];
        end
    end

    always_comb begin
        w_sel = '0;
        for (int k = DEPTH - 1; k >= 0; k--)
            if (w_rdy[k[IW-1:0]]) w_sel = k[IW-1:0];
    end

    assign issue_valid  = |w_rdy;
    assign issue_opcode = r_q[w_sel].op;
    assign issue_rd_tag = r_q[w_sel].rd;
    assign issue_imm    = r_q[w_sel].imm;
`ifdef IQ_CDB_BYPASS_EN
    assign issue_rs1_data = w_cur[w_sel].d1;
    assign issue_rs2_data = w_cur[w_sel].d2;
`else
    assign issue_rs1_data = r_q[w_sel].d1;
    assign issue_rs2_data = r_q[w_sel].d2;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_q     <= '{default: '0};
        end else begin
            r_count <= w_after + (IW+1)'(w_acc);
            r_q     <= w_nxt;
        end
    end
endmodule

// File: tb/tb_int_issue_queue.sv
// tb_int_issue_queue: directed and randomized checks of int_issue_queue against a queue model.
module tb_int_issue_queue;
    localparam int DW = 32;
    localparam int TW = 6;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          dispatch_en_integer;
    logic [4:0]    dispatch_opcode;
    logic [TW-1:0] dispatch_rd_tag, dispatch_rs1_tag, dispatch_rs2_tag;
    logic [DW-1:0] dispatch_rs1_data, dispatch_rs2_data, dispatch_imm;
    logic          dispatch_rs1_valid, dispatch_rs2_valid;
    logic          CDB_valid;
    logic [TW-1:0] CDB_tag;
    logic [DW-1:0] CDB_data;
    logic          issueque_full_integer;
    logic          issue_valid;
    logic          issue_ready;
    logic [4:0]    issue_opcode;
    logic [TW-1:0] issue_rd_tag;
    logic [DW-1:0] issue_rs1_data, issue_rs2_data, issue_imm;

    int n_pass = 0;
    int n_total = 0;

    int_issue_queue #(.DATA_WIDTH(DW), .TAG_WIDTH(TW), .DEPTH(D)) dut (
        .clk(clk), .reset(reset),
        .dispatch_en_integer(dispatch_en_integer), .dispatch_opcode(dispatch_opcode),
        .dispatch_rd_tag(dispatch_rd_tag), .dispatch_rs1_tag(dispatch_rs1_tag),
        .dispatch_rs2_tag(dispatch_rs2_tag), .dispatch_rs1_data(dispatch_rs1_data),
        .dispatch_rs2_data(dispatch_rs2_data), .dispatch_imm(dispatch_imm),
        .dispatch_rs1_valid(dispatch_rs1_valid), .dispatch_rs2_valid(dispatch_rs2_valid),
        .CDB_valid(CDB_valid), .CDB_tag(CDB_tag), .CDB_data(CDB_data),
        .issueque_full_integer(issueque_full_integer),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_opcode(issue_opcode), .issue_rd_tag(issue_rd_tag),
        .issue_rs1_data(issue_rs1_data), .issue_rs2_data(issue_rs2_data), .issue_imm(issue_imm)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]    op;
        logic [TW-1:0] rd;
        logic [DW-1:0] imm;
        bit            p1;
        logic [TW-1:0] t1;
        logic [DW-1:0] d1;
        bit            p2;
        logic [TW-1:0] t2;
        logic [DW-1:0] d2;
    } ent_t;

    ent_t mq[$];

    function automatic bit resolved(bit p, logic [TW-1:0] t);
`ifdef IQ_CDB_BYPASS_EN
        return !p || (CDB_valid && t == CDB_tag);
`else
        return !p;
`endif
    endfunction

    function automatic int oldest_ready();
        foreach (mq[i])
            if (resolved(mq[i].p1, mq[i].t1) && resolved(mq[i].p2, mq[i].t2)) return i;
        return -1;
    endfunction

    function automatic logic [DW-1:0] opnd(bit p, logic [DW-1:0] d);
        return p ? CDB_data : d;
    endfunction

    function automatic ent_t wk(ent_t e);
        ent_t r = e;
        if (CDB_valid && r.p1 && r.t1 == CDB_tag) begin r.p1 = 0; r.d1 = CDB_data; end
        if (CDB_valid && r.p2 && r.t2 == CDB_tag) begin r.p2 = 0; r.d2 = CDB_data; end
        return r;
    endfunction

    task automatic step();
        int s = oldest_ready();
        bit was_full = (mq.size() == D);
        ent_t n;
        @(posedge clk);
        if (s >= 0 && issue_ready) mq.delete(s);
        foreach (mq[i]) mq[i] = wk(mq[i]);
        if (dispatch_en_integer && !was_full) begin
            n.op = dispatch_opcode; n.rd = dispatch_rd_tag; n.imm = dispatch_imm;
            n.p1 = dispatch_rs1_valid; n.t1 = dispatch_rs1_tag; n.d1 = dispatch_rs1_data;
            n.p2 = dispatch_rs2_valid; n.t2 = dispatch_rs2_tag; n.d2 = dispatch_rs2_data;
            mq.push_back(wk(n));
        end
        #1;
    endtask

    task automatic idle();
        dispatch_en_integer = 0; dispatch_opcode = '0; dispatch_rd_tag = '0;
        dispatch_rs1_tag = '0; dispatch_rs2_tag = '0; dispatch_rs1_data = '0;
        dispatch_rs2_data = '0; dispatch_imm = '0; dispatch_rs1_valid = 0;
        dispatch_rs2_valid = 0; CDB_valid = 0; CDB_tag = '0; CDB_data = '0;
    endtask

    task automatic disp(input logic [4:0] op, input logic [TW-1:0] rd,
                        input bit v1, input logic [TW-1:0] t1, input logic [DW-1:0] d1,
                        input bit v2, input logic [TW-1:0] t2, input logic [DW-1:0] d2,
                        input logic [DW-1:0] imm);
        dispatch_en_integer = 1; dispatch_opcode = op; dispatch_rd_tag = rd;
        dispatch_rs1_valid = v1; dispatch_rs1_tag = t1; dispatch_rs1_data = d1;
        dispatch_rs2_valid = v2; dispatch_rs2_tag = t2; dispatch_rs2_data = d2;
        dispatch_imm = imm;
    endtask

    task automatic do_reset();
        idle();
        issue_ready = 0;
        reset = 0;
        mq.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1;
    endtask

    task automatic test_reset();
        idle();
        issue_ready = 1;
        reset = 0;
        #1;
        n_total++; if (issue_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", issue_valid); else n_pass++;
        n_total++; if (issueque_full_integer !== 1'b0) $display("FAIL reset_full: got %b want 0", issueque_full_integer); else n_pass++;
        do_reset();
        #1;
        n_total++; if (issue_valid !== 1'b0) $display("FAIL reset_after_valid: got %b want 0", issue_valid); else n_pass++;
    endtask

    task automatic test_basic();
        do_reset();
        issue_ready = 1;
        disp(5'd3, 6'd1, 0, 6'd0, 32'd5, 0, 6'd0, 32'd7, 32'h1234);
        #1;
        n_total++; if (issue_valid !== 1'b0) $display("FAIL basic_latency: got %b want 0", issue_valid); else n_pass++;
        step();
        idle();
        #1;
        n_total++; if (issue_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", issue_valid); else n_pass++;
        n_total++;
        if ({issue_opcode, issue_rd_tag, issue_rs1_data, issue_rs2_data, issue_imm} !== {5'd3, 6'd1, 32'd5, 32'd7, 32'h1234})
            $display("FAIL basic_fields: got op=%0d rd=%0d rs1=%0h rs2=%0h imm=%0h want 3 1 5 7 1234",
                     issue_opcode, issue_rd_tag, issue_rs1_data, issue_rs2_data, issue_imm);
        else n_pass++;
        step();
        n_total++; if (issue_valid !== 1'b0) $display("FAIL basic_empty: got %b want 0", issue_valid); else n_pass++;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            disp(5'(i), 6'(i), 0, 6'd0, 32'(i + 100), 0, 6'd0, 32'(i + 200), 32'd0);
            step();
            n_total++;
            if (issueque_full_integer !== (i == 3))
                $display("FAIL full_fill%0d: got %b want %b", i, issueque_full_integer, i == 3);
            else n_pass++;
        end
        disp(5'd9, 6'd9, 0, 6'd0, 32'd9, 0, 6'd0, 32'd9, 32'd0);
        step();
        idle();
        n_total++; if (issueque_full_integer !== 1'b1) $display("FAIL full_drop: got %b want 1", issueque_full_integer); else n_pass++;
        issue_ready = 1;
        step();
        n_total++; if (issueque_full_integer !== 1'b0) $display("FAIL full_after_issue: got %b want 0", issueque_full_integer); else n_pass++;
        for (int i = 1; i < 4; i++) begin
            n_total++;
            if (issue_valid !== 1'b1 || issue_opcode !== 5'(i) || issue_rs1_data !== 32'(i + 100))
                $display("FAIL full_drain%0d: got v=%b op=%0d rs1=%0d want v=1 op=%0d rs1=%0d",
                         i, issue_valid, issue_opcode, issue_rs1_data, i, i + 100);
            else n_pass++;
            step();
        end
        n_total++; if (issue_valid !== 1'b0) $display("FAIL full_count3: got %b want 0", issue_valid); else n_pass++;
    endtask

    task automatic test_wakeup();
        do_reset();
        disp(5'd10, 6'd2, 1, 6'd9, 32'd0, 0, 6'd0, 32'd2, 32'd0);
        step();
        disp(5'd11, 6'd3, 0, 6'd0, 32'd1, 0, 6'd0, 32'd1, 32'd0);
        step();
        idle();
        #1;
        n_total++;
        if (issue_valid !== 1'b1 || issue_opcode !== 5'd11)
            $display("FAIL wake_b_first: got v=%b op=%0d want v=1 op=11", issue_valid, issue_opcode);
        else n_pass++;
        issue_ready = 1;
        step();
        n_total++; if (issue_valid !== 1'b0) $display("FAIL wake_a_waits: got %b want 0", issue_valid); else n_pass++;
        CDB_valid = 1; CDB_tag = 6'd9; CDB_data = 32'hABCD;
        #1;
`ifdef IQ_CDB_BYPASS_EN
        n_total++;
        if (issue_valid !== 1'b1 || issue_opcode !== 5'd10 || issue_rs1_data !== 32'hABCD || issue_rs2_data !== 32'd2)
            $display("FAIL wake_bypass: got v=%b op=%0d rs1=%0h rs2=%0h want 1 10 abcd 2",
                     issue_valid, issue_opcode, issue_rs1_data, issue_rs2_data);
        else n_pass++;
        step();
        idle();
`else
        n_total++; if (issue_valid !== 1'b0) $display("FAIL wake_no_bypass: got %b want 0", issue_valid); else n_pass++;
        step();
        idle();
        #1;
        n_total++;
        if (issue_valid !== 1'b1 || issue_opcode !== 5'd10 || issue_rs1_data !== 32'hABCD || issue_rs2_data !== 32'd2)
            $display("FAIL wake_next: got v=%b op=%0d rs1=%0h rs2=%0h want 1 10 abcd 2",
                     issue_valid, issue_opcode, issue_rs1_data, issue_rs2_data);
        else n_pass++;
        step();
`endif
        n_total++; if (issue_valid !== 1'b0) $display("FAIL wake_empty: got %b want 0", issue_valid); else n_pass++;
    endtask

    task automatic test_dispatch_capture();
        do_reset();
        issue_ready = 1;
        disp(5'd4, 6'd5, 0, 6'd0, 32'd1, 1, 6'd12, 32'd0, 32'd0);
        CDB_valid = 1; CDB_tag = 6'd12; CDB_data = 32'h55;
        step();
        idle();
        #1;
        n_total++;
        if (issue_valid !== 1'b1 || issue_opcode !== 5'd4 || issue_rs1_data !== 32'd1 || issue_rs2_data !== 32'h55)
            $display("FAIL capture: got v=%b op=%0d rs1=%0h rs2=%0h want 1 4 1 55",
                     issue_valid, issue_opcode, issue_rs1_data, issue_rs2_data);
        else n_pass++;
        step();
        n_total++; if (issue_valid !== 1'b0) $display("FAIL capture_empty: got %b want 0", issue_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp_op [3];
        exp_op[0] = 5'd22; exp_op[1] = 5'd23; exp_op[2] = 5'd31;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            disp(5'(20 + i), 6'(i), 0, 6'd0, 32'(i), 0, 6'd0, 32'(i), 32'd0);
            step();
        end
        issue_ready = 1;
        disp(5'd30, 6'd0, 0, 6'd0, 32'd0, 0, 6'd0, 32'd0, 32'd0);
        #1;
        n_total++; if (issueque_full_integer !== 1'b1) $display("FAIL b2b_full: got %b want 1", issueque_full_integer); else n_pass++;
        step();
        disp(5'd31, 6'd0, 0, 6'd0, 32'd0, 0, 6'd0, 32'd0, 32'd0);
        step();
        idle();
        issue_ready = 0;
        n_total++; if (issueque_full_integer !== 1'b0) $display("FAIL b2b_count3: got %b want 0", issueque_full_integer); else n_pass++;
        issue_ready = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (issue_valid !== 1'b1 || issue_opcode !== exp_op[i])
                $display("FAIL b2b_order%0d: got v=%b op=%0d want v=1 op=%0d", i, issue_valid, issue_opcode, exp_op[i]);
            else n_pass++;
            step();
        end
        n_total++; if (issue_valid !== 1'b0) $display("FAIL b2b_empty: got %b want 0", issue_valid); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            disp(5'(i + 1), 6'd0, 0, 6'd0, 32'd0, 0, 6'd0, 32'd0, 32'd0);
            step();
        end
        idle();
        #1;
        n_total++; if (issue_valid !== 1'b1) $display("FAIL mid_busy: got %b want 1", issue_valid); else n_pass++;
        #2 reset = 0;
        mq.delete();
        #1;
        n_total++;
        if (issue_valid !== 1'b0 || issueque_full_integer !== 1'b0)
            $display("FAIL mid_reset_async: got v=%b full=%b want 0 0", issue_valid, issueque_full_integer);
        else n_pass++;
        @(posedge clk);
        #1 reset = 1;
        disp(5'd5, 6'd7, 0, 6'd0, 32'h77, 0, 6'd0, 32'h88, 32'd0);
        step();
        idle();
        #1;
        n_total++;
        if (issue_valid !== 1'b1 || issue_opcode !== 5'd5 || issue_rs1_data !== 32'h77)
            $display("FAIL mid_first_dispatch: got v=%b op=%0d rs1=%0h want 1 5 77", issue_valid, issue_opcode, issue_rs1_data);
        else n_pass++;
        issue_ready = 1;
        step();
        n_total++; if (issue_valid !== 1'b0) $display("FAIL mid_empty: got %b want 0", issue_valid); else n_pass++;
    endtask

    task automatic test_random();
        int s;
        do_reset();
        repeat (3000) begin
            dispatch_en_integer = ($urandom_range(0, 1) == 1);
            dispatch_opcode = 5'($urandom);
            dispatch_rd_tag = 6'($urandom);
            dispatch_rs1_valid = ($urandom_range(0, 2) == 0);
            dispatch_rs2_valid = ($urandom_range(0, 2) == 0);
            dispatch_rs1_tag = 6'($urandom_range(0, 7));
            dispatch_rs2_tag = 6'($urandom_range(0, 7));
            dispatch_rs1_data = $urandom;
            dispatch_rs2_data = $urandom;
            dispatch_imm = $urandom;
            CDB_valid = ($urandom_range(0, 4) < 2);
            CDB_tag = 6'($urandom_range(0, 7));
            CDB_data = $urandom;
            issue_ready = ($urandom_range(0, 4) < 3);
            #1;
            s = oldest_ready();
            n_total++;
            if (issue_valid !== (s >= 0) || issueque_full_integer !== (mq.size() == D))
                $display("FAIL rand_status: got v=%b full=%b want v=%b full=%b",
                         issue_valid, issueque_full_integer, s >= 0, mq.size() == D);
            else n_pass++;
            if (s >= 0) begin
                n_total++;
                if ({issue_opcode, issue_rd_tag, issue_imm, issue_rs1_data, issue_rs2_data} !==
                    {mq[s].op, mq[s].rd, mq[s].imm, opnd(mq[s].p1, mq[s].d1), opnd(mq[s].p2, mq[s].d2)})
                    $display("FAIL rand_fields: got op=%0d rd=%0d imm=%0h rs1=%0h rs2=%0h want op=%0d rd=%0d imm=%0h rs1=%0h rs2=%0h",
                             issue_opcode, issue_rd_tag, issue_imm, issue_rs1_data, issue_rs2_data,
                             mq[s].op, mq[s].rd, mq[s].imm, opnd(mq[s].p1, mq[s].d1), opnd(mq[s].p2, mq[s].d2));
                else n_pass++;
            end
            step();
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_wakeup();
        test_dispatch_capture();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
